// File: rtl/reg_commit_pkg.sv
// rtl/reg_commit_pkg.sv - shared types and constants for the frame-synchronous register commit controller
package reg_commit_pkg;

    // SPI-side register addresses; every other code is consumed and dropped
    typedef enum logic [2:0] {
        ADDR_COLOR1 = 3'd1,
        ADDR_COLOR2 = 3'd2,
        ADDR_COLOR3 = 3'd3,
        ADDR_COLOR4 = 3'd4,
        ADDR_MISC   = 3'd7
    } reg_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } commit_state_t;

    localparam int NUM_REGS = 5;

    // Position of each register in the dirty mask and in the commit walk
    localparam logic [2:0] IDX_COLOR1 = 3'd0;
    localparam logic [2:0] IDX_COLOR2 = 3'd1;
    localparam logic [2:0] IDX_COLOR3 = 3'd2;
    localparam logic [2:0] IDX_COLOR4 = 3'd3;
    localparam logic [2:0] IDX_MISC   = 3'd4;

    // Width of the forced-commit counter
    localparam int WD_CNT_W = 20;

    function automatic logic addr_valid(input logic [2:0] addr);
        case (addr)
            ADDR_COLOR1, ADDR_COLOR2, ADDR_COLOR3, ADDR_COLOR4, ADDR_MISC: addr_valid = 1'b1;
            default:                                                       addr_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] addr_index(input logic [2:0] addr);
        case (addr)
            ADDR_COLOR2: addr_index = IDX_COLOR2;
            ADDR_COLOR3: addr_index = IDX_COLOR3;
            ADDR_COLOR4: addr_index = IDX_COLOR4;
            ADDR_MISC:   addr_index = IDX_MISC;
            default:     addr_index = IDX_COLOR1;
        endcase
    endfunction

endpackage

// File: rtl/reg_commit_watchdog.sv
// rtl/reg_commit_watchdog.sv - forced-commit timeout counter, present only with REG_COMMIT_WATCHDOG_EN
`ifdef REG_COMMIT_WATCHDOG_EN
module reg_commit_watchdog
    import reg_commit_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic in_pending,
    output logic timeout
);

    localparam logic [WD_CNT_W-1:0] LIMIT = WD_CNT_W'(WATCHDOG_CYCLES - 1);

    logic [WD_CNT_W-1:0] cnt;

    // Count cycles spent in PENDING; held at zero everywhere else so each entry starts from zero
    always_ff @(posedge clk) begin
        if (reset || !in_pending) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = in_pending && (cnt == LIMIT);

endmodule
`endif

// File: rtl/reg_commit_ctrl.sv
// rtl/reg_commit_ctrl.sv - shadow/live display registers committed at frame start (optional REG_COMMIT_WATCHDOG_EN)
module reg_commit_ctrl
    import reg_commit_pkg::*;
#(
    parameter logic [5:0]  COLOR1_DEFAULT  = 6'd0,
    parameter logic [5:0]  COLOR2_DEFAULT  = 6'd0,
    parameter logic [5:0]  COLOR3_DEFAULT  = 6'd0,
    parameter logic [5:0]  COLOR4_DEFAULT  = 6'd0,
    parameter logic [4:0]  MISC_DEFAULT    = 5'd0,
    parameter int unsigned WATCHDOG_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic       frame_start,
    output logic [5:0] color1,
    output logic [5:0] color2,
    output logic [5:0] color3,
    output logic [5:0] color4,
    output logic [4:0] misc,
    output logic       pending,
    output logic       commit_done
);

    commit_state_t          state;
    commit_state_t          state_next;
    logic [NUM_REGS-1:0]    dirty;
    logic [NUM_REGS-1:0]    dirty_next;
    logic [2:0]             walk_idx;
    logic [5:0]             shadow_c1;
    logic [5:0]             shadow_c2;
    logic [5:0]             shadow_c3;
    logic [5:0]             shadow_c4;
    logic [4:0]             shadow_misc;
    logic                   wr_accept;
    logic [2:0]             wr_idx;
    logic                   wd_timeout;
    logic                   start_commit;
    logic                   walk_last;

`ifdef REG_COMMIT_WATCHDOG_EN
    reg_commit_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .in_pending (state == PENDING),
        .timeout    (wd_timeout)
    );
`else
    // Without the watchdog a stalled display simply leaves the writes pending
    localparam int unsigned unused_watchdog_cycles = WATCHDOG_CYCLES;
    assign wd_timeout = 1'b0;
`endif

    assign wr_accept    = wr_valid && wr_ready && addr_valid(wr_addr);
    assign wr_idx       = addr_index(wr_addr);
    assign start_commit = (state == PENDING) && (frame_start || wd_timeout);
    assign walk_last    = (walk_idx == IDX_MISC);

    // Next dirty mask and next state; a write landing in the start cycle is still picked up by the walk
    always_comb begin
        dirty_next = dirty;
        state_next = state;
        if (state == COMMIT) begin
            dirty_next[walk_idx] = 1'b0;
        end
        if (wr_accept) begin
            dirty_next[wr_idx] = 1'b1;
        end
        case (state)
            IDLE:    state_next = (dirty_next != '0) ? PENDING : IDLE;
            PENDING: state_next = start_commit ? COMMIT : PENDING;
            COMMIT:  state_next = walk_last ? IDLE : COMMIT;
            default: state_next = IDLE;
        endcase
    end

    // Controller state, shadow capture, commit walk and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dirty       <= '0;
            walk_idx    <= '0;
            wr_ready    <= 1'b0;
            pending     <= 1'b0;
            commit_done <= 1'b0;
            shadow_c1   <= COLOR1_DEFAULT;
            shadow_c2   <= COLOR2_DEFAULT;
            shadow_c3   <= COLOR3_DEFAULT;
            shadow_c4   <= COLOR4_DEFAULT;
            shadow_misc <= MISC_DEFAULT;
            color1      <= COLOR1_DEFAULT;
            color2      <= COLOR2_DEFAULT;
            color3      <= COLOR3_DEFAULT;
            color4      <= COLOR4_DEFAULT;
            misc        <= MISC_DEFAULT;
        end else begin
            state       <= state_next;
            dirty       <= dirty_next;
            pending     <= |dirty_next;
            wr_ready    <= (state_next != COMMIT);
            commit_done <= (state == COMMIT) && walk_last;
            walk_idx    <= ((state == COMMIT) && !walk_last) ? walk_idx + 3'd1 : 3'd0;

            if (wr_accept) begin
                case (wr_idx)
                    IDX_COLOR1: shadow_c1   <= wr_data;
                    IDX_COLOR2: shadow_c2   <= wr_data;
                    IDX_COLOR3: shadow_c3   <= wr_data;
                    IDX_COLOR4: shadow_c4   <= wr_data;
                    default:    shadow_misc <= wr_data[4:0];
                endcase
            end

            if ((state == COMMIT) && dirty[walk_idx]) begin
                case (walk_idx)
                    IDX_COLOR1: color1 <= shadow_c1;
                    IDX_COLOR2: color2 <= shadow_c2;
                    IDX_COLOR3: color3 <= shadow_c3;
                    IDX_COLOR4: color4 <= shadow_c4;
                    default:    misc   <= shadow_misc;
                endcase
            end
        end
    end

endmodule
